// File: rtl/alu4_seq.sv
// rtl/alu4_seq.sv - nibble-serial ALU reusing one 4-bit alu4 slice over NIBBLES cycles
// Optional zero/ovf flag outputs are enabled by defining ALU4_SEQ_FLAGS_EN.

module alu4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] sel,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);
  logic [3:0] t;
  logic [4:0] sum;

  always_comb begin
    t    = 4'h0;
    sum  = 5'h00;
    y    = 4'h0;
    cout = 1'b0;
    case (sel[1:0])
      2'b00:   t = 4'h0;
      2'b01:   t = b;
      2'b10:   t = ~b;
      default: t = 4'hF;
    endcase
    if (sel[2]) begin
      case (sel[1:0])
        2'b00:   y = a & b;
        2'b01:   y = a | b;
        2'b10:   y = a ^ b;
        default: y = ~a;
      endcase
    end else begin
      sum       = {1'b0, a} + {1'b0, t} + {4'h0, cin};
      {cout, y} = sum;
    end
  end
endmodule

module alu4_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry
`ifdef ALU4_SEQ_FLAGS_EN
  ,
  output logic                 zero,
  output logic                 ovf
`endif
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [3:0]      nib_a, nib_b, nib_y;
  logic [2:0]      nib_sel;
  logic            nib_cin, nib_cout, is_logic, last;

  assign is_logic = op_q[3];
  assign last     = (cnt_q == CW'(NIBBLES - 1));
  assign nib_a    = a_q[4*cnt_q +: 4];
  assign nib_b    = b_q[4*cnt_q +: 4];
  assign nib_sel  = is_logic ? {1'b1, op_q[1:0]} : {1'b0, op_q[2:1]};
  // Carry chains through carry_q between nibbles; the first nibble takes op[0].
  assign nib_cin  = is_logic ? 1'b0 : ((cnt_q == '0) ? op_q[0] : carry_q);

  alu4 u_alu4 (
    .a    (nib_a),
    .b    (nib_b),
    .sel  (nib_sel),
    .cin  (nib_cin),
    .y    (nib_y),
    .cout (nib_cout)
  );

`ifdef ALU4_SEQ_FLAGS_EN
  logic ovf_q, ovf_d, t_msb;

  always_comb begin
    t_msb = 1'b0;
    case (op_q[2:1])
      2'b00:   t_msb = 1'b0;
      2'b01:   t_msb = b_q[W-1];
      2'b10:   t_msb = ~b_q[W-1];
      default: t_msb = 1'b1;
    endcase
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid)
      ovf_d = 1'b0;
    else if (state_q == RUN && last)
      ovf_d = !is_logic && (a_q[W-1] == t_msb) && (nib_y[3] != a_q[W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign zero = (state_q == DONE) && (result_q == '0);
  assign ovf  = (state_q == DONE) && ovf_q;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          carry_d = 1'b0;
        end
      end
      RUN: begin
        result_d[4*cnt_q +: 4] = nib_y;
        carry_d                = nib_cout;
        if (last) state_d = DONE;
        else      cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 4'h0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry     = carry_q;
endmodule

// File: tb/tb_alu4_seq.sv
// tb/tb_alu4_seq.sv - directed and random checks of alu4_seq against an arithmetic reference
module tb_alu4_seq;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, carry;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;
`ifdef ALU4_SEQ_FLAGS_EN
  logic         zero, ovf;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu4_seq #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry)
`ifdef ALU4_SEQ_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] t_of(input logic [3:0] o, input logic [W-1:0] y);
    case (o[2:1])
      2'b00:   return '0;
      2'b01:   return y;
      2'b10:   return ~y;
      default: return '1;
    endcase
  endfunction

  function automatic logic [W:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    if (o[3]) begin
      case (o[1:0])
        2'b00:   return {1'b0, x & y};
        2'b01:   return {1'b0, x | y};
        2'b10:   return {1'b0, x ^ y};
        default: return {1'b0, ~x};
      endcase
    end
    return {1'b0, x} + {1'b0, t_of(o, y)} + (W+1)'(o[0]);
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb, input int stall);
    logic [W:0]   want;
    logic [W-1:0] held;
    int           lat;
    want = model(o, xa, xb);
    @(negedge clk);
    check("ready_before", in_ready, 1);
    op = o; a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, NIB);
    check("result", result, want[W-1:0]);
    check("carry", carry, want[W]);
`ifdef ALU4_SEQ_FLAGS_EN
    check("zero", zero, want[W-1:0] == '0);
    check("ovf", ovf, !o[3] && (xa[W-1] == t_of(o, xb) >> (W-1)) && (want[W-1] != xa[W-1]));
`endif
    held = result;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      op = 4'($urandom); a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_result", result, held);
      check("hold_busy", {in_ready, out_valid}, 2'b01);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 4'h0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry, 0);

    do_op(4'b0010, 16'h0FFF, 16'h0001, 0);
    do_op(4'b0101, 16'h0003, 16'h0005, 1);
    do_op(4'b0101, 16'h8000, 16'h0001, 2);
    do_op(4'b0110, 16'h0000, 16'h1234, 0);
    do_op(4'b0001, 16'hFFFF, 16'h0000, 0);
    do_op(4'b1010, 16'hF0F0, 16'hFF00, 10);

    @(negedge clk);
    op = 4'b0010; a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_result", result, 0);
    check("abort_state", {in_ready, out_valid}, 2'b10);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_valid", out_valid, 0);
    end
    do_op(4'b0010, 16'h0001, 16'h0001, 0);

    for (int n = 0; n < 64; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(4'(n % 16), W'($urandom), W'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu4_seq.md
ALU4_SEQ -- requirements
Module: alu4_seq

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: in_valid  in  1  request present.
REQ-005 Port: in_ready  out  1  request can be accepted.
REQ-006 Port: op  in  4  opcode.
- op[3]=0: arithmetic; op[2:0] = {alu select[1:0], initial carry_in}.
- op[3]=1: logic; alu select = {1, op[1:0]}, giving AND/OR/XOR/NOT; op[2] is ignored.
REQ-007 Port: a  in  W  operand A.
REQ-008 Port: b  in  W  operand B.
REQ-009 Port: out_valid  out  1  result present.
REQ-010 Port: out_ready  in  1  consumer accepts result.
REQ-011 Port: result  out  W  operation result.
REQ-012 Port: carry  out  1  carry out of the top nibble; 0 for logic ops.

Function
REQ-013 Block shall contain exactly one alu4 instance and time-multiplex it over all nibbles, LSB nibble first.
REQ-014 FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on in_valid&&in_ready, which latches op, a, b and clears the nibble counter.
- RUN -> DONE on the edge that captures the last nibble.
- DONE -> IDLE on out_valid&&out_ready.
REQ-015 in_ready = 1 only in IDLE; out_valid = 1 only in DONE; no back-to-back accept from DONE.
REQ-016 RUN nibble i drives alu4 with a[4i+3:4i] and b[4i+3:4i].
- Arithmetic: carry_in is op[0] for i=0, and the registered alu4 carry_out of nibble i-1 otherwise.
- Logic: carry_in = 0.
REQ-017 Nibble i output is captured into result[4i+3:4i] at the end of RUN cycle i; the counter wraps to 0 only via IDLE.
REQ-018 Latency: accept edge E0; out_valid is high from edge E(NIBBLES) onward; throughput is one op per NIBBLES+2 cycles minimum.
REQ-019 Arithmetic semantics: {carry,result} = a + T + op[0] mod 2^(W+1), where T is selected by op[2:1]:
- 00: T = 0
- 01: T = b
- 10: T = ~b
- 11: T = all-ones
REQ-020 Logic semantics: result = a&b, a|b, a^b or ~a per op[1:0]=00/01/10/11; carry = 0.
REQ-021 result and carry shall hold stable throughout DONE regardless of a, b, op or in_valid changes.
REQ-022 Inputs sampled outside the IDLE accept edge shall have no effect.

Reset
REQ-023 rst high at an edge shall force IDLE, counter 0, result 0, carry 0, out_valid 0 (flags 0 when present); in_ready = 1 from the first edge with rst low.
REQ-024 rst asserted during RUN or DONE shall abort and discard the operation; no out_valid follows.

Configuration
REQ-025 Macro ALU4_SEQ_FLAGS_EN adds two outputs, both valid with out_valid and reset to 0:
- zero: result == 0.
- ovf: signed overflow for arithmetic, = (a[W-1]==T[W-1]) && (result[W-1]!=a[W-1]); 0 for logic.
REQ-026 Without ALU4_SEQ_FLAGS_EN, zero and ovf ports and their logic shall be absent; all other behaviour is identical.

Verification
REQ-027 NIBBLES=4, ADD (op=0010), a=0x0FFF, b=0x0001 -> result=0x1000, carry=0, out_valid exactly 4 edges after accept.
REQ-028 SUBTRACT (op=0101), a=0x0003, b=0x0005 -> result=0xFFFE, carry=0, ovf=0; same with a=0x8000, b=0x0001 -> result=0x7FFF, carry=1, ovf=1.
REQ-029 DECREMENT (op=0110), a=0x0000 -> result=0xFFFF, carry=0, zero=0; INCREMENT (op=0001), a=0xFFFF -> result=0x0000, carry=1, zero=1.
REQ-030 XOR (op=1010), a=0xF0F0, b=0xFF00, with out_ready held low 10 cycles -> result=0x0FF0, carry=0; result stable and in_ready=0 for all 10 cycles; IDLE one edge after out_ready.
REQ-031 rst pulsed during RUN nibble 2 of ADD 0x1234+0x1111 -> no out_valid, result=0; next request ADD 0x0001+0x0001 -> 0x0002.
REQ-032 Random regression over all 16 opcodes, with random out_ready/in_valid gaps, shall match REQ-019/020 against a W-bit reference model.
